// File: rtl/mem_copier.sv
// mem_copier: copies or fills up to 64 words of a 64x16 RAM, one READ/WRITE pair per word
module mem_copier (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  input  logic [5:0]  src_base,
  input  logic [5:0]  dst_base,
  input  logic [6:0]  count,
  input  logic [15:0] fill_value,
  output logic        busy,
  output logic        done,
  output logic        mem_load,
  output logic [5:0]  mem_address,
  output logic [15:0] mem_in,
  input  logic [15:0] mem_out
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t      state;
  logic        mode_r;
  logic [5:0]  src_r, dst_r;
  logic [6:0]  cnt_r, idx;
  logic [15:0] fill_r, data_r;
  logic [6:0]  idx_n, cnt_sat;
  assign idx_n   = idx + 7'd1;
  assign cnt_sat = count > 7'd64 ? 7'd64 : count;
  // outputs are registered alongside the state, so each transition loads the target state's outputs
  always_ff @(posedge clk)
    if (reset) begin
      state       <= IDLE;
      mode_r      <= 1'b0;
      src_r       <= '0;
      dst_r       <= '0;
      cnt_r       <= '0;
      fill_r      <= '0;
      idx         <= '0;
      data_r      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_load    <= 1'b0;
      mem_address <= '0;
      mem_in      <= '0;
    end else begin
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_load    <= 1'b0;
      mem_address <= '0;
      mem_in      <= '0;
      case (state)
        IDLE:
          if (start) begin
            mode_r <= mode;
            src_r  <= src_base;
            dst_r  <= dst_base;
            cnt_r  <= cnt_sat;
            fill_r <= fill_value;
            idx    <= '0;
            if (cnt_sat == 7'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (mode) begin
              state       <= WRITE;
              busy        <= 1'b1;
              mem_load    <= 1'b1;
              mem_address <= dst_base;
              mem_in      <= fill_value;
            end else begin
              state       <= READ;
              busy        <= 1'b1;
              mem_address <= src_base;
            end
          end
        READ: begin
          data_r      <= mem_out;
          state       <= WRITE;
          busy        <= 1'b1;
          mem_load    <= 1'b1;
          mem_address <= dst_r + idx[5:0];
          mem_in      <= mem_out;
        end
        WRITE: begin
          idx <= idx_n;
          if (idx_n == cnt_r) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (mode_r) begin
            state       <= WRITE;
            busy        <= 1'b1;
            mem_load    <= 1'b1;
            mem_address <= dst_r + idx_n[5:0];
            mem_in      <= fill_r;
          end else begin
            state       <= READ;
            busy        <= 1'b1;
            mem_address <= src_r + idx_n[5:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_copier.sv
// tb_mem_copier: table-driven transfers against a scoreboard of expected RAM writes
module tb_mem_copier;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [5:0]  src_base = '0, dst_base = '0;
  logic [6:0]  count = '0;
  logic [15:0] fill_value = '0;
  logic        busy, done, mem_load;
  logic [5:0]  mem_address;
  logic [15:0] mem_in, mem_out;
  logic        pl_we = 1'b0;
  logic [5:0]  pl_a = '0;
  logic [15:0] pl_d = '0;
  logic [15:0] ram [64];
  logic [15:0] mref [64];
  typedef struct {logic [5:0] a; logic [15:0] d;} wr_t;
  wr_t sbq [$];
  typedef struct {logic m; logic [5:0] s; logic [5:0] d; logic [6:0] c; logic [15:0] f; int lat; int poke;} vec_t;
  vec_t vt [8];
  int checks = 0, failures = 0, nwr = 0, nbusy = 0, ndone = 0;

  mem_copier dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .src_base(src_base),
    .dst_base(dst_base), .count(count), .fill_value(fill_value), .busy(busy),
    .done(done), .mem_load(mem_load), .mem_address(mem_address), .mem_in(mem_in),
    .mem_out(mem_out)
  );

  always #5 clk = ~clk;
  assign mem_out = ram[mem_address];
  always @(posedge clk)
    if (mem_load) ram[mem_address] <= mem_in;
    else if (pl_we) ram[pl_a] <= pl_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (mem_load) begin
      nwr++;
      if (sbq.size() == 0) chk("unexpected_write", {10'd0, mem_address, mem_in}, 32'hFFFF_FFFF);
      else begin
        e = sbq.pop_front();
        chk("write_addr", 32'(mem_address), 32'(e.a));
        chk("write_data", 32'(mem_in), 32'(e.d));
        mref[e.a] = e.d;
      end
    end
    if (busy) nbusy++;
    if (done) ndone++;
    if (!busy) chk("idle_outputs", {9'd0, mem_load, mem_address, mem_in}, 32'd0);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [5:0] a, input logic [15:0] d);
    pl_we = 1'b1; pl_a = a; pl_d = d;
    tick;
    pl_we = 1'b0;
    mref[a] = d;
  endtask

  // expected write stream from an in-order replay on a scratch copy of the model
  task automatic prep(input logic m, input logic [5:0] s, input logic [5:0] d, input int c, input logic [15:0] f);
    logic [15:0] tmp [64];
    wr_t e;
    for (int i = 0; i < 64; i++) tmp[i] = mref[i];
    for (int i = 0; i < c; i++) begin
      e.a = 6'(d + 6'(i));
      e.d = m ? f : tmp[6'(s + 6'(i))];
      tmp[e.a] = e.d;
      sbq.push_back(e);
    end
  endtask

  task automatic chk_image;
    int bad = 0;
    for (int i = 0; i < 64; i++) if (ram[i] !== mref[i]) bad++;
    chk("ram_image", bad, 0);
  endtask

  task automatic run(input vec_t v);
    int cs, w0, b0, d0, lat;
    cs = v.c > 64 ? 64 : int'(v.c);
    w0 = nwr; b0 = nbusy; d0 = ndone;
    prep(v.m, v.s, v.d, cs, v.f);
    mode = v.m; src_base = v.s; dst_base = v.d; count = v.c; fill_value = v.f; start = 1'b1;
    tick;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 400) begin
      if (lat == v.poke) begin
        start = 1'b1; mode = ~v.m; src_base = v.s + 6'd13; dst_base = v.d + 6'd7; count = 7'd5; fill_value = ~v.f;
      end else start = 1'b0;
      tick;
      lat++;
    end
    start = 1'b0;
    chk("latency", lat, v.lat);
    chk("write_count", nwr - w0, cs);
    chk("busy_cycles", nbusy - b0, v.m ? cs : 2 * cs);
    tick;
    chk("done_pulses", ndone - d0, 1);
    chk("idle_after", {busy, done}, 0);
    chk("sb_empty", sbq.size(), 0);
    chk_image;
  endtask

  initial begin
    int w0, d0;
    for (int i = 0; i < 64; i++) preload(6'(i), 16'($urandom));
    preload(6'd5, 16'hA00A); preload(6'd6, 16'hB00B); preload(6'd7, 16'hC00C); preload(6'd8, 16'hD00D);
    for (int i = 0; i < 4; i++) preload(6'(i), 16'(i + 1));
    chk("reset_outputs", {busy, done, mem_load, mem_address, mem_in}, 0);
    reset = 1'b0;
    tick;
    chk("idle_hold", {busy, done}, 0);
    vt[0] = '{1'b0, 6'd0,  6'd1,  7'd3,   16'h0,    7,   0};
    vt[1] = '{1'b0, 6'd5,  6'd40, 7'd4,   16'h0,    9,   0};
    vt[2] = '{1'b1, 6'd0,  6'd62, 7'd4,   16'hBEEF, 5,   0};
    vt[3] = '{1'b0, 6'd9,  6'd50, 7'd0,   16'h0,    1,   0};
    vt[4] = '{1'b0, 6'd60, 6'd10, 7'd6,   16'h0,    13,  4};
    vt[5] = '{1'b1, 6'd0,  6'd7,  7'd100, 16'h1234, 65,  2};
    vt[6] = '{1'b0, 6'd0,  6'd32, 7'd64,  16'h0,    129, 0};
    vt[7] = '{1'b1, 6'd20, 6'd20, 7'd1,   16'h5A5A, 2,   0};
    for (int i = 0; i < 8; i++) begin
      run(vt[i]);
      if (i == 0) chk("overlap_result", {ram[0][3:0], ram[1][3:0], ram[2][3:0], ram[3][3:0]}, 32'h1111);
      if (i == 1) chk("copy_result", {ram[40], ram[41]} ^ {ram[42], ram[43]}, {16'hA00A ^ 16'hC00C, 16'hB00B ^ 16'hD00D});
    end
    w0 = nwr; d0 = ndone;
    prep(1'b0, 6'd10, 6'd20, 8, 16'h0);
    mode = 1'b0; src_base = 6'd10; dst_base = 6'd20; count = 7'd8; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (5) tick;
    chk("third_write_active", mem_load, 1'b1);
    reset = 1'b1;
    tick;
    chk("abort_outputs", {busy, done, mem_load, mem_address, mem_in}, 0);
    reset = 1'b0;
    chk("abort_writes", (nwr - w0 == 2) || (nwr - w0 == 3), 1);
    sbq.delete();
    w0 = nwr;
    repeat (20) tick;
    chk("abort_no_more_writes", nwr - w0, 0);
    chk("abort_no_done", ndone - d0, 0);
    chk_image;
    mode = 1'b1; dst_base = 6'd30; count = 7'd4; fill_value = 16'h7777; start = 1'b1; reset = 1'b1;
    tick;
    start = 1'b0; reset = 1'b0;
    chk("reset_priority", {busy, done}, 0);
    repeat (6) tick;
    chk("reset_priority_writes", nwr - w0, 0);
    chk("reset_priority_done", ndone - d0, 0);
    chk_image;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_copier.md
MEM_COPIER -- requirements
Module: mem_copier

Interface
REQ-001 The block SHALL have no parameters; address width is fixed at 6 (64 words) and data width at 16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 mode  input  1  0 = copy, 1 = fill.
REQ-006 src_base  input  6  first source word address (copy mode).
REQ-007 dst_base  input  6  first destination word address.
REQ-008 count  input  7  number of words to transfer, 0..64.
REQ-009 fill_value  input  16  word written in fill mode.
REQ-010 busy  output  1  high while a transfer is in progress.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 mem_load  output  1  write enable to the 64-word RAM load port.
REQ-013 mem_address  output  6  RAM address port.
REQ-014 mem_in  output  16  RAM write-data port.
REQ-015 mem_out  input  16  RAM read data; combinational function of mem_address.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, READ, WRITE and DONE.
REQ-017 In IDLE, start=1 SHALL latch mode, src_base, dst_base, count and fill_value, clear the word index, and transition to:
- DONE if count=0;
- WRITE if mode=1;
- READ otherwise.
REQ-018 In IDLE, start=0 SHALL hold IDLE; start in any other state SHALL be ignored and SHALL NOT alter latched operands.
REQ-019 READ SHALL drive mem_address=(src+idx) mod 64 with mem_load=0, capture mem_out into the data register at the clock edge, and go to WRITE.
REQ-020 WRITE SHALL drive mem_address=(dst+idx) mod 64 with mem_load=1.
REQ-021 In WRITE, mem_in SHALL equal the data register in copy mode and latched fill_value in fill mode.
REQ-022 At the edge ending WRITE, idx SHALL increment; if the new idx equals count the next state SHALL be DONE, else READ (copy) or WRITE (fill).
REQ-023 DONE SHALL assert done=1 for exactly one cycle and return to IDLE.
REQ-024 busy SHALL be 1 in READ and WRITE, and 0 in IDLE and DONE.
REQ-025 In IDLE and DONE, mem_load=0, mem_address=0 and mem_in=0.
REQ-026 Address arithmetic SHALL wrap modulo 64 (e.g. base 62, idx 3 gives address 1).
REQ-027 Words SHALL be transferred in ascending idx order; overlapping src/dst ranges yield exactly the result of that ordered sequence.
REQ-028 count values above 64 SHALL be saturated to 64 when latched.
REQ-029 Latency from the start edge to the done pulse SHALL be:
- copy: 2*count+1 cycles;
- fill: count+1 cycles;
- count=0: 1 cycle.
REQ-030 mem_load SHALL be asserted exactly count times per transfer, never twice for the same idx.

Reset
REQ-031 reset=1 SHALL force IDLE at the next edge from any state, with busy=0, done=0, mem_load=0, mem_address=0, mem_in=0, idx=0 and data register=0.
REQ-032 reset asserted mid-transfer SHALL abort immediately; words already written remain, and no further writes occur.
REQ-033 reset and start asserted together SHALL give priority to reset.

Verification
REQ-034 Copy: preload RAM[5..8]=A,B,C,D; start mode=0, src=5, dst=40, count=4 -> RAM[40..43]=A,B,C,D, done at cycle 9, RAM[5..8] unchanged.
REQ-035 Fill wrap: start mode=1, dst=62, count=4, fill=0xBEEF -> RAM[62], RAM[63], RAM[0], RAM[1]=0xBEEF, done at cycle 5, other words untouched.
REQ-036 Zero count: start with count=0 -> done pulses at the next cycle, busy never high, mem_load never high.
REQ-037 Overlap: RAM[0..3]=1,2,3,4; copy src=0, dst=1, count=3 -> RAM[0..3]=1,1,1,1.
REQ-038 Reset mid-copy: assert reset during the third WRITE of a count=8 copy -> IDLE next cycle, exactly 2 or 3 words written, no done pulse.
REQ-039 Busy re-start: pulse start with new operands while busy -> ignored; original transfer completes with original operands and a single done pulse.
